// File: rtl/lcd_frame_ctrl.sv
// lcd_frame_ctrl: command/pixel sequencer feeding the SPI LCD byte driver.
// Runs the power-up init table once, programs the full-screen window, then
// streams RGB565 pixels as two data bytes each over a valid/done handshake.
// Optional build macro: LCD_BGR_SWAP_EN (send pixels as BGR, MADCTL = 0x08).
module lcd_frame_ctrl #(
  parameter int unsigned H_RES      = 128,
  parameter int unsigned V_RES      = 160,
  parameter int unsigned PWR_WAIT   = 1000,
  parameter int unsigned DELAY_UNIT = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        lcd_valid,
  output logic        lcd_index_or_data,
  output logic [7:0]  lcd_data,
  input  logic        lcd_done,
  output logic        busy,
  output logic        init_done,
  output logic        frame_done
);

  localparam int unsigned DLY_MAX = 255 * DELAY_UNIT;
  localparam int unsigned CNT_MAX = (PWR_WAIT > DLY_MAX) ? PWR_WAIT : DLY_MAX;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned NPIX    = H_RES * V_RES;
  localparam int unsigned PW      = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [3:0]  WIN_LAST = 4'd10;

`ifdef LCD_BGR_SWAP_EN
  localparam logic [7:0] MADCTL = 8'h08;
`else
  localparam logic [7:0] MADCTL = 8'h00;
`endif

  typedef enum logic [1:0] {E_CMD, E_DATA, E_DELAY, E_END} entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_INIT_ISSUE, S_INIT_WAIT, S_DELAY, S_WIN_ISSUE, S_WIN_WAIT,
    S_PIX_FETCH, S_PIX_HI, S_PIX_HI_WAIT, S_PIX_LO, S_PIX_LO_WAIT, S_FRAME_END, S_READY
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [3:0]      ptr;
  logic [PW-1:0]   pix_cnt;
  logic [15:0]     pix_q;
  logic [9:0]      entry;
  entry_t          ety;
  logic [7:0]      eby;
  logic [8:0]      win;

  // Init table: {type, byte}
  function automatic logic [9:0] init_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    init_rom = {E_CMD,   8'h01};
      4'd1:    init_rom = {E_DELAY, 8'd150};
      4'd2:    init_rom = {E_CMD,   8'h11};
      4'd3:    init_rom = {E_DELAY, 8'd120};
      4'd4:    init_rom = {E_CMD,   8'h3A};
      4'd5:    init_rom = {E_DATA,  8'h05};
      4'd6:    init_rom = {E_CMD,   8'h36};
      4'd7:    init_rom = {E_DATA,  MADCTL};
      4'd8:    init_rom = {E_CMD,   8'h29};
      default: init_rom = {E_END,   8'h00};
    endcase
  endfunction

  // Window sequence: {index_or_data, byte}
  function automatic logic [8:0] win_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    win_rom = {1'b0, 8'h2A};
      4'd4:    win_rom = {1'b1, 8'(H_RES - 1)};
      4'd5:    win_rom = {1'b0, 8'h2B};
      4'd9:    win_rom = {1'b1, 8'(V_RES - 1)};
      4'd10:   win_rom = {1'b0, 8'h2C};
      default: win_rom = {1'b1, 8'h00};
    endcase
  endfunction

  function automatic logic [15:0] pix_map(input logic [15:0] p);
`ifdef LCD_BGR_SWAP_EN
    pix_map = {p[4:0], p[10:5], p[15:11]};
`else
    pix_map = p;
`endif
  endfunction

  assign entry = init_rom(ptr);
  assign ety   = entry_t'(entry[9:8]);
  assign eby   = entry[7:0];
  assign win   = win_rom(ptr);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Counters, table pointer, pixel latch and sticky init flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      ptr       <= '0;
      pix_cnt   <= '0;
      pix_q     <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE:       if (start) cnt <= CW'(PWR_WAIT - 1);
        S_PWR:        if (cnt != '0) cnt <= cnt - 1'b1;
        S_INIT_ISSUE: begin
          if (ety == E_DELAY)
            cnt <= (eby == 8'd0) ? '0 : CW'(eby) * CW'(DELAY_UNIT) - 1'b1;
          else if (ety == E_END) begin
            init_done <= 1'b1;
            ptr       <= '0;
          end
        end
        S_INIT_WAIT:  if (lcd_done) ptr <= ptr + 1'b1;
        S_DELAY: begin
          if (cnt == '0) ptr <= ptr + 1'b1;
          else           cnt <= cnt - 1'b1;
        end
        S_WIN_WAIT: begin
          if (lcd_done) begin
            if (ptr == WIN_LAST) begin
              ptr     <= '0;
              pix_cnt <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        S_PIX_FETCH:   if (pix_valid) pix_q <= pix_map(pix_data);
        S_PIX_LO_WAIT: if (lcd_done && pix_cnt != PW'(NPIX - 1)) pix_cnt <= pix_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and outputs; byte/type are a pure function of state so they
  // stay stable throughout the wait state without extra registers
  always_comb begin
    state_nxt         = state;
    lcd_valid         = 1'b0;
    lcd_index_or_data = 1'b0;
    lcd_data          = 8'h00;
    pix_ready         = 1'b0;
    busy              = 1'b1;
    frame_done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_PWR;
      end
      S_PWR: if (cnt == '0) state_nxt = S_INIT_ISSUE;
      S_INIT_ISSUE: begin
        case (ety)
          E_CMD, E_DATA: begin
            lcd_valid         = 1'b1;
            lcd_index_or_data = (ety == E_DATA);
            lcd_data          = eby;
            state_nxt         = S_INIT_WAIT;
          end
          E_DELAY: state_nxt = S_DELAY;
          default: state_nxt = S_WIN_ISSUE;
        endcase
      end
      S_INIT_WAIT: begin
        lcd_index_or_data = (ety == E_DATA);
        lcd_data          = eby;
        if (lcd_done) state_nxt = S_INIT_ISSUE;
      end
      S_DELAY: if (cnt == '0) state_nxt = S_INIT_ISSUE;
      S_WIN_ISSUE: begin
        lcd_valid                      = 1'b1;
        {lcd_index_or_data, lcd_data}  = win;
        state_nxt                      = S_WIN_WAIT;
      end
      S_WIN_WAIT: begin
        {lcd_index_or_data, lcd_data} = win;
        if (lcd_done) state_nxt = (ptr == WIN_LAST) ? S_PIX_FETCH : S_WIN_ISSUE;
      end
      S_PIX_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_nxt = S_PIX_HI;
      end
      S_PIX_HI: begin
        lcd_valid         = 1'b1;
        lcd_index_or_data = 1'b1;
        lcd_data          = pix_q[15:8];
        state_nxt         = S_PIX_HI_WAIT;
      end
      S_PIX_HI_WAIT: begin
        lcd_index_or_data = 1'b1;
        lcd_data          = pix_q[15:8];
        if (lcd_done) state_nxt = S_PIX_LO;
      end
      S_PIX_LO: begin
        lcd_valid         = 1'b1;
        lcd_index_or_data = 1'b1;
        lcd_data          = pix_q[7:0];
        state_nxt         = S_PIX_LO_WAIT;
      end
      S_PIX_LO_WAIT: begin
        lcd_index_or_data = 1'b1;
        lcd_data          = pix_q[7:0];
        if (lcd_done) state_nxt = (pix_cnt == PW'(NPIX - 1)) ? S_FRAME_END : S_PIX_FETCH;
      end
      S_FRAME_END: begin
        frame_done = 1'b1;
        state_nxt  = S_READY;
      end
      S_READY: begin
        busy = 1'b0;
        if (start) state_nxt = S_WIN_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl with a small frame and short delays.
// Driver model answers each lcd_valid with lcd_done 20 cycles later.
module tb_lcd_frame_ctrl;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned PW = 10;
  localparam int unsigned DU = 4;
  localparam int NPIX = H * V;

`ifdef LCD_BGR_SWAP_EN
  localparam logic [7:0] MAD = 8'h08;
`else
  localparam logic [7:0] MAD = 8'h00;
`endif

  localparam logic [8:0] INIT_EXP [7] = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, {1'b1, MAD}, 9'h029};
  localparam logic [8:0] WIN_EXP [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                                          9'h02B, 9'h100, 9'h100, 9'h100, 9'h102, 9'h02C};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_ready;
  logic        lcd_valid;
  logic        lcd_index_or_data;
  logic [7:0]  lcd_data;
  logic        lcd_done = 1'b0;
  logic        busy;
  logic        init_done;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int viol = 0;
  int pr_cycles = 0;
  int fd_count = 0;
  int fd_bytes = 0;
  int acc = 0;
  int mode = 0;
  int s_cyc = 0;
  int dcnt = 0;
  bit pending = 0;
  bit hs = 0;
  logic [8:0] held = '0;
  logic [8:0] byte_q [$];
  int         byte_t [$];

  lcd_frame_ctrl #(.H_RES(H), .V_RES(V), .PWR_WAIT(PW), .DELAY_UNIT(DU)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .lcd_valid(lcd_valid), .lcd_index_or_data(lcd_index_or_data),
    .lcd_data(lcd_data), .lcd_done(lcd_done), .busy(busy), .init_done(init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pix_val(input int k);
    if (mode == 0)   return 16'hF81F;
    else if (k == 0) return 16'hF800;
    else             return 16'h1234 + 16'(k) * 16'h0111;
  endfunction

  function automatic logic [15:0] expect_pix(input logic [15:0] p);
`ifdef LCD_BGR_SWAP_EN
    return {p[4:0], p[10:5], p[15:11]};
`else
    return p;
`endif
  endfunction

  // Driver model and byte monitor
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      lcd_done = 1'b0;
      pending  = 0;
      dcnt     = 0;
    end else begin
      if (pending && {lcd_index_or_data, lcd_data} !== held) viol++;
      lcd_done = 1'b0;
      if (pending) begin
        dcnt--;
        if (dcnt == 0) begin
          lcd_done = 1'b1;
          pending  = 0;
        end
      end
      if (lcd_valid) begin
        if (pending) viol++;
        byte_q.push_back({lcd_index_or_data, lcd_data});
        byte_t.push_back(cyc);
        held    = {lcd_index_or_data, lcd_data};
        pending = 1;
        dcnt    = 20;
      end
      if (pix_ready) pr_cycles++;
      if (frame_done) begin
        fd_count++;
        fd_bytes = byte_q.size();
      end
    end
  end

  // Pixel source: advance to the next pixel after each accepted handshake
  always begin
    @(negedge clk);
    hs = pix_valid && pix_ready && rstn;
    @(posedge clk);
    #1;
    if (hs) begin
      acc++;
      pix_data = pix_val(acc);
    end
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget, output bit ok);
    int i = 0;
    while (byte_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (byte_q.size() >= n);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (lcd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_lcd_valid got %b want 0", lcd_valid); end
    vectors++; if (lcd_data !== 8'h00) begin miscompares++; $display("FAIL reset_lcd_data got %h want 00", lcd_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", init_done); end
    vectors++; if ({pix_ready, frame_done, lcd_index_or_data} !== 3'b000) begin miscompares++; $display("FAIL reset_misc got %b want 000", {pix_ready, frame_done, lcd_index_or_data}); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_init(input int base, input string tag);
    bit ok;
    int i;
    wait_q(base + 1, 100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_first_byte timeout", tag); end
    // start seen on the following edge, PWR_WAIT cycles in PWR, then the issue cycle
    else if (byte_t[base] - s_cyc !== PW + 1) begin
      miscompares++; $display("FAIL %s_pwr_wait got %0d want %0d", tag, byte_t[base] - s_cyc, PW + 1);
    end
    pulse_start;
    i = 0;
    while (init_done !== 1'b1 && i < 4000) begin @(negedge clk); i++; end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL %s_init_done timeout got %b", tag, init_done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy got %b want 1", tag, busy); end
    wait_q(base + 7, 10, ok);
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (base + k >= byte_q.size()) begin miscompares++; $display("FAIL %s_byte%0d missing", tag, k); end
      else if (byte_q[base + k] !== INIT_EXP[k]) begin
        miscompares++; $display("FAIL %s_byte%0d got %h want %h", tag, k, byte_q[base + k], INIT_EXP[k]);
      end
    end
    if (byte_q.size() >= base + 4) begin
      // 20-cycle driver latency + issue of the delay entry + the delay itself
      vectors++; if (byte_t[base + 1] - byte_t[base] !== 150 * DU + 22) begin miscompares++; $display("FAIL %s_delay150 got %0d want %0d", tag, byte_t[base + 1] - byte_t[base], 150 * DU + 22); end
      vectors++; if (byte_t[base + 2] - byte_t[base + 1] !== 120 * DU + 22) begin miscompares++; $display("FAIL %s_delay120 got %0d want %0d", tag, byte_t[base + 2] - byte_t[base + 1], 120 * DU + 22); end
      vectors++; if (byte_t[base + 3] - byte_t[base + 2] !== 21) begin miscompares++; $display("FAIL %s_byte_gap got %0d want 21", tag, byte_t[base + 3] - byte_t[base + 2]); end
    end
  endtask

  task automatic test_init;
    mode = 0; acc = 0; pix_data = pix_val(0); pix_valid = 1'b1; pr_cycles = 0;
    pulse_start;
    check_init(0, "init");
  endtask

  task automatic test_window;
    bit ok;
    wait_q(18, 600, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL window timeout got %0d bytes", byte_q.size()); end
    for (int k = 0; k < 11; k++) begin
      vectors++;
      if (7 + k >= byte_q.size()) begin miscompares++; $display("FAIL window_byte%0d missing", k); end
      else if (byte_q[7 + k] !== WIN_EXP[k]) begin
        miscompares++; $display("FAIL window_byte%0d got %h want %h", k, byte_q[7 + k], WIN_EXP[k]);
      end
    end
  endtask

  task automatic test_pixels;
    int i = 0;
    while (acc < 6 && i < 1000) begin @(negedge clk); i++; end
    pulse_start;
    i = 0;
    while (fd_count < 1 && i < 2000) begin @(negedge clk); i++; end
    repeat (30) @(negedge clk);
    vectors++; if (byte_q.size() !== 18 + 2 * NPIX) begin miscompares++; $display("FAIL frame1_size got %0d want %0d", byte_q.size(), 18 + 2 * NPIX); end
    for (int k = 0; k < 2 * NPIX && 18 + k < byte_q.size(); k++) begin
      vectors++;
      if (byte_q[18 + k] !== ((k % 2 == 0) ? 9'h1F8 : 9'h11F)) begin
        miscompares++; $display("FAIL frame1_byte%0d got %h want %h", k, byte_q[18 + k], (k % 2 == 0) ? 9'h1F8 : 9'h11F);
      end
    end
    vectors++; if (fd_count !== 1) begin miscompares++; $display("FAIL frame1_done_count got %0d want 1", fd_count); end
    vectors++; if (fd_bytes !== 18 + 2 * NPIX) begin miscompares++; $display("FAIL frame1_done_pos got %0d want %0d", fd_bytes, 18 + 2 * NPIX); end
    vectors++; if (acc !== NPIX) begin miscompares++; $display("FAIL frame1_accepted got %0d want %0d", acc, NPIX); end
    vectors++; if (pr_cycles !== NPIX) begin miscompares++; $display("FAIL frame1_ready_cycles got %0d want %0d", pr_cycles, NPIX); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ready_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int base, i, n0, n1;
    logic [15:0] p;
    logic [8:0] e;
    base = byte_q.size();
    mode = 1; acc = 0; pix_data = pix_val(0);
    pulse_start;
    i = 0;
    while (acc < 5 && i < 1000) begin @(negedge clk); i++; end
    pix_valid = 1'b0;
    repeat (100) @(negedge clk);
    n0 = byte_q.size();
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready got %b want 1", pix_ready); end
    repeat (400) @(negedge clk);
    n1 = byte_q.size();
    vectors++; if (n0 !== base + 11 + 10) begin miscompares++; $display("FAIL stall_bytes_before got %0d want %0d", n0 - base, 21); end
    vectors++; if (n1 !== n0) begin miscompares++; $display("FAIL stall_quiet got %0d bytes want 0", n1 - n0); end
    pix_valid = 1'b1;
    i = 0;
    while (fd_count < 2 && i < 2000) begin @(negedge clk); i++; end
    repeat (30) @(negedge clk);
    vectors++; if (byte_q.size() !== base + 11 + 2 * NPIX) begin miscompares++; $display("FAIL frame2_size got %0d want %0d", byte_q.size() - base, 11 + 2 * NPIX); end
    for (int k = 0; k < 11 + 2 * NPIX && base + k < byte_q.size(); k++) begin
      if (k < 11) e = WIN_EXP[k];
      else begin
        p = expect_pix(pix_val((k - 11) / 2));
        e = ((k - 11) % 2 == 0) ? {1'b1, p[15:8]} : {1'b1, p[7:0]};
      end
      vectors++;
      if (byte_q[base + k] !== e) begin miscompares++; $display("FAIL frame2_byte%0d got %h want %h", k, byte_q[base + k], e); end
    end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL frame2_init_done got %b want 1", init_done); end
    vectors++; if (fd_count !== 2) begin miscompares++; $display("FAIL frame2_done_count got %0d want 2", fd_count); end
  endtask

  task automatic test_midreset;
    int base;
    bit ok;
    base = byte_q.size();
    mode = 1; acc = 0; pix_data = pix_val(0);
    pulse_start;
    wait_q(base + 12, 600, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL midreset_reach timeout"); end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("FAIL midreset_init_done got %b want 0", init_done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b want 0", busy); end
    vectors++; if ({lcd_valid, lcd_index_or_data, lcd_data} !== 10'h000) begin miscompares++; $display("FAIL midreset_lcd got %h want 000", {lcd_valid, lcd_index_or_data, lcd_data}); end
    vectors++; if ({pix_ready, frame_done} !== 2'b00) begin miscompares++; $display("FAIL midreset_misc got %b want 00", {pix_ready, frame_done}); end
    #20 rstn = 1'b1;
    repeat (2) @(negedge clk);
    base = byte_q.size();
    pulse_start;
    check_init(base, "reinit");
  endtask

  task automatic test_protocol;
    vectors++; if (viol !== 0) begin miscompares++; $display("FAIL handshake_protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_init;
    test_window;
    test_pixels;
    test_back_to_back;
    test_midreset;
    test_protocol;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_frame_ctrl.md
Name: lcd_frame_ctrl

Overview:
- Upstream command/pixel sequencer for the SPI LCD byte driver.
- Runs a fixed power-up/init command table, programs the full-screen window, then streams RGB565 pixels from a pixel source, splitting each into two bytes.
- Issues one byte at a time over a pulse/done handshake to the driver; the driver owns the SPI wires.

Parameters:
- H_RES, 128, horizontal pixels per frame (column end = H_RES-1).
- V_RES, 160, vertical lines per frame (row end = V_RES-1).
- PWR_WAIT, 1000, clk cycles waited after start before the first init byte.
- DELAY_UNIT, 1000, clk cycles per unit of a table delay entry.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins init+frame (first time) or frame only (after init)
- pix_valid  in  1  upstream pixel available
- pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
- pix_ready  out  1  pixel accepted when pix_valid&pix_ready
- lcd_valid  out  1  one-cycle byte request to driver
- lcd_index_or_data  out  1  0=command byte, 1=data byte; held stable from lcd_valid until lcd_done
- lcd_data  out  8  byte to send; held stable from lcd_valid until lcd_done
- lcd_done  in  1  driver one-cycle byte-complete pulse
- busy  out  1  high in every state except IDLE/READY
- init_done  out  1  sticky high once the init table completes
- frame_done  out  1  one-cycle pulse after the last pixel's low byte completes

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, init_done cleared. An async reset mid-transfer aborts immediately; the driver is reset by the same rstn.
- Byte handshake: lcd_valid is high exactly one cycle per byte, then the FSM waits for lcd_done. The next lcd_valid comes no earlier than the cycle after lcd_done. lcd_valid is never asserted while a byte is outstanding. lcd_done while not waiting is ignored.
- Init table: internal ROM, 10-bit entries {type[1:0],byte[7:0]}. Types: 00 cmd, 01 data, 10 delay of byte*DELAY_UNIT cycles, 11 end.
- Table contents, in order:
  - cmd 0x01, delay 150
  - cmd 0x11, delay 120
  - cmd 0x3A, data 0x05
  - cmd 0x36, data 0x00
  - cmd 0x29, end
- Window sequence (fixed, 11 bytes): cmd 0x2A, data 0x00, 0x00, 0x00, H_RES-1; cmd 0x2B, data 0x00, 0x00, 0x00, V_RES-1; cmd 0x2C.
- States:
  - IDLE: start -> PWR, counter loaded with PWR_WAIT-1.
  - PWR: counts down to 0 -> INIT_ISSUE.
  - INIT_ISSUE: reads entry at the table pointer. cmd/data -> pulse lcd_valid -> INIT_WAIT. delay -> DELAY. end -> set init_done, pointer=0 -> WIN_ISSUE.
  - INIT_WAIT: lcd_done -> pointer+1 -> INIT_ISSUE.
  - DELAY: counts byte*DELAY_UNIT cycles (zero-byte delay = 1 cycle), then pointer+1 -> INIT_ISSUE.
  - WIN_ISSUE/WIN_WAIT: same pattern over the 11 window bytes -> PIX_FETCH, pixel counter=0.
  - PIX_FETCH: pix_ready=1 combinationally. On pix_valid, latch pixel -> PIX_HI. If pix_valid is low, wait indefinitely; stalls are unbounded.
  - PIX_HI: data byte pix[15:8] -> PIX_HI_WAIT.
  - PIX_HI_WAIT: lcd_done -> PIX_LO.
  - PIX_LO: data byte pix[7:0] -> PIX_LO_WAIT.
  - PIX_LO_WAIT: lcd_done. If pixel counter == H_RES*V_RES-1 -> FRAME_END, else counter+1 -> PIX_FETCH.
  - FRAME_END: frame_done=1 for one cycle -> READY.
  - READY: start -> WIN_ISSUE (no re-init).
- start while busy is ignored. Counter widths sized by $clog2 of the parameter products; no wrap before terminal count.

Optional Feature:
- Macro LCD_BGR_SWAP_EN.
- When defined: the latched pixel is transmitted as {B,G,R` (B[4:0] in bits 15:11, R[4:0] in bits 4:0), and the init table's 0x36 data byte is 0x08.
- When undefined: the pixel is sent unmodified and the 0x36 data byte is 0x00.

Test Plan:
- Reset then start pulse, driver model returns lcd_done 20 cycles after each lcd_valid -> no lcd_valid for PWR_WAIT cycles. Byte stream begins 0x01(cmd), then ~150000 idle cycles, 0x11, ~120000 idle, 0x3A, 0x05(data), 0x36, 0x00, 0x29. init_done rises; 11 window bytes follow with column end 0x7F, row end 0x9F.
- Pixel stream with pix_data=0xF81F held valid -> each pixel gives bytes 0xF8 then 0x1F (data). pix_ready pulses once per pixel. frame_done pulses once after 20480 pixels (40960 data bytes).
- pix_valid deasserted for 500 cycles mid-frame -> no lcd_valid during the stall; the stream resumes with the correct next pixel, with no skipped or duplicated bytes.
- start pulsed during init and mid-frame -> ignored; start in READY -> window bytes resent with no init bytes, init_done stays 1.
- rstn asserted mid-pixel (between hi and lo byte) -> all outputs 0 asynchronously, init_done=0. The next start replays the full init from 0x01.
- With LCD_BGR_SWAP_EN defined, pix_data=0xF800 -> bytes 0x00, 0x1F, and the init 0x36 data byte = 0x08.
